// File: rtl/xgriscv_lsu.sv
// xgriscv_lsu: MEM-stage load/store unit. Steers store bytes onto a word bus,
// extracts and extends load data, flags misalignment and bounds each access with a timeout.

module xgriscv_lsu_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] width,
    input  logic [1:0] off,
    input  logic [7:0] b_src,
    input  logic [7:0] h_src,
    input  logic [7:0] w_src,
    output logic       be,
    output logic [7:0] wbyte
);
    localparam logic [1:0] LIDX = 2'(LANE);

    always_comb begin
        be    = 1'b0;
        wbyte = b_src;
        unique case (width)
            2'b01: be = (off == LIDX);
            2'b10: begin
                be    = (off[1] == LIDX[1]);
                wbyte = h_src;
            end
            2'b11: begin
                be    = 1'b1;
                wbyte = w_src;
            end
            default: ;
        endcase
    end
endmodule

module xgriscv_lsu #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          memwrite,
    input  logic [1:0]    lwhb,
    input  logic [1:0]    swhb,
    input  logic          lunsigned,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          req_ready,
    output logic          stall,
    output logic          resp_valid,
    output logic [31:0]   rdata,
    output logic          misaligned,
    output logic          bus_err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [3:0]    bus_be,
    output logic [AW-1:0] bus_addr,
    output logic [31:0]   bus_wdata,
    input  logic          bus_gnt,
    input  logic          bus_rvalid,
    input  logic [31:0]   bus_rdata
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, REQ, WAITR, RESP} state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] width;
        logic       uns;
        logic [1:0] off;
    } acc_t;

    state_t                     state;
    acc_t                       acc;
    logic [7:0]                 tcnt;
    logic [1:0]                 width;
    logic                       misal;
    logic                       tmo;
    logic [NUM_LANES-1:0]       be_nxt;
    logic [NUM_LANES-1:0][7:0]  wd_nxt;
    logic [31:0]                shifted;
    logic [31:0]                ld_data;

    assign width = memwrite ? swhb : lwhb;
    assign misal = (width == 2'b00) || (width == 2'b10 && addr[0]) ||
                   (width == 2'b11 && addr[1:0] != 2'b00);
    // tcnt holds cycles already spent, so this cycle is the TIMEOUT-th one
    assign tmo   = (TIMEOUT != 0) && (tcnt == 8'(TIMEOUT - 1));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        xgriscv_lsu_lane #(.LANE(i)) u_lane (
            .width (width),
            .off   (addr[1:0]),
            .b_src (wdata[7:0]),
            .h_src (wdata[8*(i%2) +: 8]),
            .w_src (wdata[8*i +: 8]),
            .be    (be_nxt[i]),
            .wbyte (wd_nxt[i])
        );
    end

    assign shifted = bus_rdata >> {acc.off, 3'b000};

    always_comb begin
        unique case (acc.width)
            2'b01:   ld_data = {{24{~acc.uns & shifted[7]}}, shifted[7:0]};
            2'b10:   ld_data = {{16{~acc.uns & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    assign req_ready = reset && (state == IDLE);
    assign stall     = reset && ((state == IDLE && req_valid) || state == REQ || state == WAITR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= '0;
            tcnt       <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            resp_valid <= 1'b0;
            rdata      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (req_valid) begin
                    acc.we    <= memwrite;
                    acc.width <= width;
                    acc.uns   <= lunsigned;
                    acc.off   <= addr[1:0];
                    tcnt      <= '0;
                    if (misal) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        misaligned <= 1'b1;
                    end else begin
                        state     <= REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= memwrite;
                        bus_be    <= be_nxt;
                        bus_addr  <= {addr[AW-1:2], 2'b00};
                        bus_wdata <= wd_nxt;
                    end
                end
                REQ: begin
                    tcnt <= tcnt + 8'd1;
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (acc.we) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAITR;
                        end
                    end else if (tmo) begin
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                    end
                end
                WAITR: begin
                    tcnt <= tcnt + 8'd1;
                    if (bus_rvalid) begin
                        rdata      <= ld_data;
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else if (tmo) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    rdata      <= '0;
                    misaligned <= 1'b0;
                    bus_err    <= 1'b0;
                end
            endcase
        end
    end
endmodule
